// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - serial generator of an N-bit word with K low-order ones
// Pattern source for the popcount datapath; uses the same start/done ASM style.
module ones_pattern_gen #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s,
    input  logic [CW-1:0] Count,
    output logic [N-1:0]  A,
    output logic [CW-1:0] B,
    output logic          z,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CW-1:0] NMAX = CW'(N);

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            A     <= '0;
            B     <= '0;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        A <= '0;
                        if (Count <= NMAX) begin
                            B     <= Count;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            // Out-of-range request: report at once, never shift
                            B     <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (B != '0) begin
                        A <= {A[N-2:0], 1'b1};
                        B <= B - CW'(1);
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Held start does not retrigger; a low s is needed to rearm
                    if (!s) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign z = (B == '0);

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - self-checking bench for ones_pattern_gen
// Timeline model plus directed vectors with literal expectations.
module tb_ones_pattern_gen;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic [N-1:0]  a;
    logic [CW-1:0] b;
    logic          z, busy, done, err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ones_pattern_gen #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s(s), .Count(cnt),
        .A(a), .B(b), .z(z), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running, 2 done; j = edges since the start edge
    int m_mode = 0, m_k = 0, m_j = 0, m_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_k <= 0; m_j <= 0; m_err <= 0;
        end else begin
            case (m_mode)
                0: if (s) begin
                    m_j <= 0;
                    if (int'(cnt) > N) begin
                        m_k <= 0; m_err <= 1; m_mode <= 2;
                    end else begin
                        m_k <= int'(cnt); m_err <= 0; m_mode <= 1;
                    end
                end
                1: begin
                    m_j <= m_j + 1;
                    if (m_j + 1 == m_k + 1) m_mode <= 2;
                end
                default: if (!s) m_mode <= 0;
            endcase
        end
    end

    function automatic int exp_a();
        int m;
        m = (m_j < m_k) ? m_j : m_k;
        return ((1 << m) - 1) & ((1 << N) - 1);
    endfunction

    function automatic int exp_b();
        int m;
        m = (m_j < m_k) ? m_j : m_k;
        return m_k - m;
    endfunction

    function automatic int popcount(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        #2;
        if (chk_en && !rst) begin
            chk("cyc_A", int'(a), exp_a());
            chk("cyc_B", int'(b), exp_b());
            chk("cyc_z", int'(z), int'(exp_b() == 0));
            chk("cyc_busy", int'(busy), int'(m_mode == 1));
            chk("cyc_done", int'(done), int'(m_mode == 2));
            chk("cyc_err", int'(err), m_err);
        end
    end

    // Start pulse; returns at the negedge after edge 0 with Count scrambled
    task automatic start(input int k);
        @(negedge clk);
        s = 1'b1;
        cnt = CW'(k);
        @(negedge clk);
        s = 1'b0;
        cnt = CW'($urandom_range(0, 7));
    endtask

    task automatic run_k(input int k, input int exp_edge, input int exp_av, input int exp_e);
        int edge_n;
        start(k);
        edge_n = 0;
        while (!done && edge_n < 20) begin
            @(negedge clk);
            edge_n++;
        end
        chk($sformatf("done_edge_k%0d", k), edge_n, exp_edge);
        chk($sformatf("final_A_k%0d", k), int'(a), exp_av);
        chk($sformatf("final_err_k%0d", k), int'(err), exp_e);
        if (exp_e == 0) chk($sformatf("loopback_k%0d", k), popcount(a), k);
    endtask

    initial begin
        #1;
        #20;
        chk("rst_A", int'(a), 0);
        chk("rst_B", int'(b), 0);
        chk("rst_z", int'(z), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Nominal K=3 step by step
        start(3);
        chk("nom_A0", int'(a), 4'b0000);
        chk("nom_B0", int'(b), 3);
        chk("nom_busy0", int'(busy), 1);
        @(negedge clk);
        chk("nom_A1", int'(a), 4'b0001);
        chk("nom_B1", int'(b), 2);
        @(negedge clk);
        chk("nom_A2", int'(a), 4'b0011);
        chk("nom_B2", int'(b), 1);
        @(negedge clk);
        chk("nom_A3", int'(a), 4'b0111);
        chk("nom_B3", int'(b), 0);
        chk("nom_done3", int'(done), 0);
        @(negedge clk);
        chk("nom_done4", int'(done), 1);
        chk("nom_A4", int'(a), 4'b0111);
        chk("nom_err4", int'(err), 0);
        chk("model_A4", exp_a(), 7);
        @(negedge clk);
        chk("nom_idle_done", int'(done), 0);
        chk("nom_idle_holdA", int'(a), 4'b0111);

        // Boundaries, loopback over all valid K
        for (int k = 0; k <= N; k++) run_k(k, k + 1, (1 << k) - 1, 0);
        chk("k0_z", int'(z), 1);

        // Error request, then a valid run clears err
        run_k(5, 0, 0, 1);
        chk("err_busy", int'(busy), 0);
        chk("model_err", m_err, 1);
        run_k(2, 3, 4'b0011, 0);

        // Start held through DONE
        @(negedge clk);
        @(negedge clk);
        s = 1'b1;
        cnt = 3'd2;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        cnt = 3'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_done", int'(done), 1);
            chk("held_A", int'(a), 4'b0011);
        end
        s = 1'b0;
        @(negedge clk);
        chk("held_release_done", int'(done), 0);
        run_k(1, 2, 4'b0001, 0);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        start(3);
        @(negedge clk);
        @(negedge clk);
        chk("mid_A", int'(a), 4'b0011);
        chk("mid_B", int'(b), 1);
        rst = 1'b1;
        #1;
        chk("arst_A", int'(a), 0);
        chk("arst_B", int'(b), 0);
        chk("arst_z", int'(z), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_A", int'(a), 0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
